// File: rtl/adc_sampler_pkg.sv
// adc_sampler_pkg: shared FSM states, LTC2308 config-word layout and helpers
package adc_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV_PULSE,
        ST_CONV_WAIT,
        ST_SHIFT,
        ST_LATCH
    } sampler_state_e;

    localparam int CONV_PULSE_CYCLES = 2;

    localparam int CFG_SD  = 11;
    localparam int CFG_OS  = 10;
    localparam int CFG_S1  = 9;
    localparam int CFG_S0  = 8;
    localparam int CFG_UNI = 7;
    localparam int CFG_SLP = 6;

    // Single-ended, unipolar, awake; left-aligned so it shifts out MSB first.
    function automatic logic [11:0] cfg_word(input logic [2:0] ch);
        logic [11:0] w;
        w          = '0;
        w[CFG_SD]  = 1'b1;
        w[CFG_OS]  = ch[0];
        w[CFG_S1]  = ch[2];
        w[CFG_S0]  = ch[1];
        w[CFG_UNI] = 1'b1;
        w[CFG_SLP] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/sample_averager.sv
// sample_averager: box average of 2^AVG_LOG2 samples with a one-cycle valid pulse
module sample_averager #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        out_valid,
    output logic [11:0] out_data
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt_q;
    logic [11:0]   data_q;
    logic          valid_q;
    logic          last;

    assign sum       = acc_q + AW'(in_data);
    assign last      = cnt_q == CW'((1 << AVG_LOG2) - 1);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Accumulate kept samples; on the last one publish the truncated mean and restart
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid && last && !clear;
            if (clear) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (in_valid) begin
                acc_q <= last ? '0 : sum;
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                if (last) data_q <= 12'(sum >> AVG_LOG2);
            end
        end
    end

endmodule

// File: rtl/adc_feedback_sampler.sv
// adc_feedback_sampler: drives the LTC2308, captures one channel per period and box-averages it
module adc_feedback_sampler
    import adc_sampler_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 250,
    parameter int CHANNEL       = 0,
    parameter int AVG_LOG2      = 2
) (
    input  logic        clock_50Min,
    input  logic        reset_n,
    input  logic        enable,
    output logic        ADC_CONVST,
    output logic        ADC_SCK,
    output logic        ADC_SDI,
    input  logic        ADC_SDO,
    output logic [11:0] V_feedback,
    output logic        sample_valid
);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int TW = $clog2(CONV_CYCLES + CONV_PULSE_CYCLES + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    sampler_state_e state_q, state_d;
    logic [PW-1:0]  per_q;
    logic [TW-1:0]  tmr_q;
    logic [DW-1:0]  div_q;
    logic [3:0]     bit_q;
    logic [11:0]    cfg_q;
    logic [11:0]    rx_q;
    logic           sck_q;
    logic           primed_q;
    logic           keep_q;
    logic           wrap;
    logic           start;
    logic           pulse_end;
    logic           wait_end;
    logic           half_end;
    logic           shift_end;
    logic           in_valid;

    assign wrap       = per_q == PW'(SAMPLE_PERIOD - 1);
    assign start      = enable && wrap && state_q == ST_IDLE;
    assign pulse_end  = tmr_q == TW'(CONV_PULSE_CYCLES - 1);
    assign wait_end   = tmr_q == TW'(CONV_CYCLES - 1);
    assign half_end   = div_q == DW'(CLK_DIV - 1);
    assign shift_end  = half_end && sck_q && bit_q == 4'd11;
    assign in_valid   = state_q == ST_LATCH && keep_q && enable;
    assign ADC_CONVST = state_q == ST_CONV_PULSE;
    assign ADC_SCK    = sck_q;
    assign ADC_SDI    = cfg_q[11];

    // Frame-rate counter, parked at zero while sampling is disabled
    always_ff @(posedge clock_50Min or negedge reset_n) begin
        if (!reset_n) per_q <= '0;
        else          per_q <= (!enable || wrap) ? '0 : per_q + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clock_50Min or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Frame sequencing; a wrap that finds the FSM busy is simply lost
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = start     ? ST_CONV_PULSE : ST_IDLE;
            ST_CONV_PULSE: state_d = pulse_end ? ST_CONV_WAIT  : ST_CONV_PULSE;
            ST_CONV_WAIT:  state_d = wait_end  ? ST_SHIFT      : ST_CONV_WAIT;
            ST_SHIFT:      state_d = shift_end ? ST_LATCH      : ST_SHIFT;
            ST_LATCH:      state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Dwell timer shared by the CONVST pulse and the conversion wait
    always_ff @(posedge clock_50Min or negedge reset_n) begin
        if (!reset_n) tmr_q <= '0;
        else          tmr_q <= (state_d == state_q && (state_q == ST_CONV_PULSE || state_q == ST_CONV_WAIT)) ? tmr_q + 1'b1 : '0;
    end

    // SCK divider and shift registers: SDI advances as SCK falls, SDO is taken as SCK rises
    always_ff @(posedge clock_50Min or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= '0;
            cfg_q <= '0;
            rx_q  <= '0;
        end else if (state_q == ST_SHIFT) begin
            div_q <= half_end ? '0 : div_q + 1'b1;
            if (half_end) begin
                sck_q <= !sck_q;
                if (!sck_q) begin
                    rx_q <= {rx_q[10:0], ADC_SDO};
                end else begin
                    cfg_q <= {cfg_q[10:0], 1'b0};
                    bit_q <= bit_q + 1'b1;
                end
            end
        end else begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= '0;
            cfg_q <= (state_q == ST_CONV_WAIT && wait_end) ? cfg_word(3'(CHANNEL)) : '0;
        end
    end

    // The ADC returns the previous frame's conversion, so the first frame after enable only primes it
    always_ff @(posedge clock_50Min or negedge reset_n) begin
        if (!reset_n) begin
            primed_q <= 1'b0;
            keep_q   <= 1'b0;
        end else if (!enable) begin
            primed_q <= 1'b0;
            keep_q   <= 1'b0;
        end else if (start) begin
            keep_q   <= primed_q;
            primed_q <= 1'b1;
        end
    end

    sample_averager #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk      (clock_50Min),
        .reset_n  (reset_n),
        .clear    (!enable),
        .in_valid (in_valid),
        .in_data  (rx_q),
        .out_valid(sample_valid),
        .out_data (V_feedback)
    );

endmodule

// File: tb/tb_adc_feedback_sampler.sv
// tb_adc_feedback_sampler: randomized check of the sampler against an ADC model and averaging reference
module tb_adc_feedback_sampler;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        sdo    = 1'b0;
    logic        conv, sck, sdi, vld;
    logic [11:0] vfb;
    logic        rst2_n = 1'b0;
    logic        sdo2   = 1'b0;
    logic        conv2, sck2, sdi2, vld2;
    logic [11:0] vfb2;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int n_frames = 0, sck_cnt = 0, n_valid = 0, last_vcyc = 0;
    int n_frames2 = 0, t2 = 0;
    bit fixed = 0, primed = 0, skip_chk = 0, frame_seen = 0, primed2 = 0;
    logic        vld_prev = 1'b0, vld2_prev = 1'b0;
    logic [11:0] sh = '0, sh2 = '0, fixed_w = '0, sdi_bits = '0;
    logic [11:0] script_q[$], kept_q[$], exp_q[$], exp2_q[$];
    time t_conv = 0, t_sck = 0, t_conv2 = 0;

    adc_feedback_sampler #(.CHANNEL(5)) u_dut (
        .clock_50Min(clk), .reset_n(rst_n), .enable(en),
        .ADC_CONVST(conv), .ADC_SCK(sck), .ADC_SDI(sdi), .ADC_SDO(sdo),
        .V_feedback(vfb), .sample_valid(vld)
    );

    adc_feedback_sampler #(.SAMPLE_PERIOD(100), .CHANNEL(3), .AVG_LOG2(0)) u_fast (
        .clock_50Min(clk), .reset_n(rst2_n), .enable(1'b1),
        .ADC_CONVST(conv2), .ADC_SCK(sck2), .ADC_SDI(sdi2), .ADC_SDO(sdo2),
        .V_feedback(vfb2), .sample_valid(vld2)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valids(input int target, input int budget, input string tag);
        int k = 0;
        while (n_valid < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_valid < target) check({tag, "_timeout"}, n_valid, target);
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k = 0;
        while (n_frames < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_frames < target) check({tag, "_timeout"}, n_frames, target);
    endtask

    // ADC model: serves a word per frame; reference keeps post-priming words and averages groups of four
    always @(posedge conv) begin
        logic [11:0] w;
        int s;
        if (frame_seen && !skip_chk) begin
            check("sck_pulses", sck_cnt, 12);
            check("sdi_word", int'(sdi_bits), 'hE80);
        end
        frame_seen = 1;
        skip_chk   = 0;
        sck_cnt    = 0;
        sdi_bits   = '0;
        t_conv     = $time;
        n_frames++;
        if (fixed) w = fixed_w;
        else if (script_q.size() > 0) w = script_q.pop_front();
        else w = 12'($urandom);
        sh  = w;
        sdo = w[11];
        if (primed) begin
            kept_q.push_back(w);
            if (kept_q.size() == 4) begin
                s = 0;
                foreach (kept_q[i]) s += int'(kept_q[i]);
                exp_q.push_back(12'(s >> 2));
                kept_q.delete();
            end
        end
        primed = 1;
    end

    always @(negedge conv) if (rst_n) check("convst_high", int'($time - t_conv), 40);

    always @(posedge sck) begin
        if (sck_cnt > 0) check("sck_period", int'($time - t_sck), 80);
        t_sck    = $time;
        sck_cnt++;
        sdi_bits = {sdi_bits[10:0], sdi};
    end

    always @(negedge sck) begin
        if (rst_n) check("sck_high", int'($time - t_sck), 40);
        sh  = {sh[10:0], 1'b0};
        sdo = sh[11];
    end

    always @(posedge conv2) begin
        logic [11:0] w;
        if (n_frames2 > 0) check("fast_start_gap", int'($time - t_conv2), 4000);
        t_conv2 = $time;
        n_frames2++;
        w    = 12'($urandom);
        sh2  = w;
        sdo2 = w[11];
        if (primed2) exp2_q.push_back(w);
        primed2 = 1;
    end

    always @(negedge conv2) check("fast_convst_high", int'($time - t_conv2), 40);

    always @(negedge sck2) begin
        sh2  = {sh2[10:0], 1'b0};
        sdo2 = sh2[11];
    end

    always @(negedge clk) begin
        if (vld) begin
            n_valid++;
            last_vcyc = cyc;
            check("valid_pulse", int'(vld_prev), 0);
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else check("v_feedback", int'(vfb), int'(exp_q.pop_front()));
        end
        if (vld2) begin
            check("fast_valid_pulse", int'(vld2_prev), 0);
            if (exp2_q.size() == 0) check("fast_unexpected_valid", 1, 0);
            else check("fast_v_feedback", int'(vfb2), int'(exp2_q.pop_front()));
        end
        vld_prev  = vld;
        vld2_prev = vld2;
    end

    initial begin
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        t2     = cyc;
    end

    initial begin
        int t0, t1, nv, nf, hold, k;
        en      = 1'b1;
        fixed   = 1;
        fixed_w = 12'hA5C;
        repeat (3) @(negedge clk);
        check("rst_convst", int'(conv), 0);
        check("rst_sck", int'(sck), 0);
        check("rst_sdi", int'(sdi), 0);
        check("rst_vfb", int'(vfb), 0);
        check("rst_valid", int'(vld), 0);
        rst_n = 1'b1;
        t0    = cyc;
        wait_valids(1, 1500, "first_valid");
        check("first_valid_lat", last_vcyc - t0, 1381);
        check("first_valid_val", int'(vfb), 'hA5C);
        t1 = last_vcyc;
        wait_valids(2, 1100, "second_valid");
        check("valid_interval", last_vcyc - t1, 1000);

        fixed    = 0;
        script_q = '{12'd100, 12'd101, 12'd102, 12'd103};
        wait_valids(3, 1100, "avg_valid");
        check("avg_trunc", int'(vfb), 101);
        wait_valids(9, 6500, "random_valids");

        nv = n_valid;
        wait_frames(n_frames + 3, 1000, "third_sample");
        repeat (90) @(negedge clk);
        check("drop_in_shift", int'(sck_cnt > 0 && sck_cnt < 12), 1);
        hold = int'(vfb);
        en   = 1'b0;
        primed = 0;
        kept_q.delete();
        exp_q.delete();
        nf = n_frames;
        repeat (300) @(negedge clk);
        check("no_valid_disabled", n_valid, nv);
        check("vfb_hold", int'(vfb), hold);
        check("no_frame_disabled", n_frames, nf);
        en = 1'b1;
        t0 = cyc;
        wait_valids(nv + 1, 1500, "reenable_valid");
        check("reenable_lat", last_vcyc - t0, 1381);

        wait_frames(n_frames + 1, 300, "reset_frame");
        k = 0;
        while (!sck && k < 4000) begin
            #1;
            k++;
        end
        if (!sck) check("rst_sck_wait", int'(sck), 1);
        #5;
        check("pre_rst_sdi", int'(sdi), 1);
        rst_n    = 1'b0;
        skip_chk = 1;
        primed   = 0;
        kept_q.delete();
        exp_q.delete();
        #1;
        check("midrst_convst", int'(conv), 0);
        check("midrst_sck", int'(sck), 0);
        check("midrst_sdi", int'(sdi), 0);
        check("midrst_vfb", int'(vfb), 0);
        check("midrst_valid", int'(vld), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t0    = cyc;
        nv    = n_valid;
        wait_valids(nv + 1, 1500, "post_reset_valid");
        check("post_reset_lat", last_vcyc - t0, 1381);

        check("fast_frames", n_frames2, (cyc - t2 - 100) / 200 + 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
